adder_seq_ctrl: RTL and testbench

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

---
 rtl/adder_seq_pkg.sv | 12 +
 rtl/adder_slice3.sv | 16 +
 rtl/adder_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_adder_seq_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the digit-serial adder controller.
package adder_seq_pkg;

  localparam int unsigned DIGIT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_slice3.sv
// Combinational 3-bit full-adder slice, shared across all digits of an operand.
module adder_slice3
  import adder_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] a3,
  input  logic [DIGIT_W-1:0] b3,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s3,
  output logic               co
);

  localparam int unsigned SUM_W = DIGIT_W + 1;

  assign {co, s3} = SUM_W'(a3) + SUM_W'(b3) + SUM_W'(ci);

endmodule

// File: rtl/adder_seq_ctrl.sv
// Digit-serial adder: one 3-bit slice walks the operands LSD first, with a
// ready/valid request side and a ready/valid result side.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*NDIG-1:0] a,
  input  logic [DIGIT_W*NDIG-1:0] b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*NDIG-1:0] sum,
  output logic                    cout,
  output logic                    busy
);

  localparam int unsigned W     = DIGIT_W * NDIG;
  localparam int unsigned IDX_W = $clog2(NDIG);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [DIGIT_W-1:0] a_dig, b_dig, s3;
  logic               co;
  logic               last_dig;

  assign last_dig = (idx_q == IDX_W'(NDIG - 1));

  // Select the current digit of each captured operand.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[i*DIGIT_W +: DIGIT_W];
        b_dig = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  adder_slice3 u_slice (
    .a3 (a_dig),
    .b3 (b_dig),
    .ci (carry_q),
    .s3 (s3),
    .co (co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)               state_d = RUN;
      RUN:     if (last_dig)               state_d = DONE;
      DONE:    if (out_ready)              state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  // Datapath updates and registered handshake flags derived from next state.
  always_comb begin
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
        end
      end
      RUN: begin
        for (int i = 0; i < int'(NDIG); i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*DIGIT_W +: DIGIT_W] = s3;
        end
        carry_d = co;
        if (last_dig) cout_d = co;
        else          idx_d  = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Randomized self-checking bench for adder_seq_ctrl (NDIG=4, 12-bit operands).
module tb_adder_seq_ctrl;

  localparam int unsigned NDIG = 4;
  localparam int unsigned W    = 12;

  logic         clk, rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;

  int n_checks = 0;
  int n_pass   = 0;

  adder_seq_ctrl #(.NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer addition, split into sum and carry-out.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return (W+1)'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request/response; hold = cycles out_ready stays low in DONE;
  // pulse_7ff = drive a stray 0x7FF request mid-computation.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input int hold, input bit pulse_7ff);
    logic [W:0] exp;
    int n;
    bit got;
    exp = model(ta, tb_, tc);
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      in_valid = 1'($urandom);
      if (pulse_7ff && n == 1) begin a = 12'h7FF; in_valid = 1'b1; end
      tick();
      n++;
      if (out_valid) got = 1;
    end
    in_valid = 1'b0;
    check("latency", 32'(n), NDIG);
    for (int k = 0; k < hold; k++) begin
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, 32'(exp[W-1:0]));
      check("hold_cout", cout, 32'(exp[W]));
      tick();
    end
    check("sum", sum, 32'(exp[W-1:0]));
    check("cout", cout, 32'(exp[W]));
    check("busy_done", busy, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
    check("busy_after", busy, 0);
    check("sum_kept", sum, 32'(exp[W-1:0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0]  exp;
    logic [24:0] q[$];
    logic [24:0] e;
    int nres, last, cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;

    do_txn(12'hFFF, 12'h001, 1'b0, 0, 0);
    do_txn(12'h123, 12'h456, 1'b1, 0, 0);
    do_txn(12'h5A5, 12'h3C3, 1'b0, 5, 0);
    do_txn(12'h001, 12'h001, 1'b0, 0, 1);

    // Abort mid-computation with an asynchronous reset.
    a = 12'hFFF; b = 12'hFFF; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("busy_run", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    rst = 1'b0;
    do_txn(12'h800, 12'h800, 1'b0, 0, 0);

    for (int i = 0; i < 20; i++)
      do_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 0);

    // Streaming with both handshakes tied high.
    nres = 0; last = -1;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    for (cyc = 0; cyc < 200 && nres < 8; cyc++) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("stream_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          exp = model(e[11:0], e[23:12], e[24]);
          check("stream_sum", sum, 32'(exp[W-1:0]));
          check("stream_cout", cout, 32'(exp[W]));
        end
        if (last >= 0) check("stream_period", 32'(cyc - last), NDIG + 2);
        last = cyc;
        nres++;
      end
      if (in_ready) q.push_back({cin, b, a});
      tick();
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    in_valid = 1'b0;
    check("stream_count", 32'(nres), 8);
    tick();
    check("stream_drained", 32'(q.size()), 0);
    check("stream_idle", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
